// File: rtl/data_bus_responder.sv
// Data-bus target: word-organised RAM with programmable wait states, byte/half/word lane
// access and a registered error response for rejected requests.
module data_bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_r,
  input  logic        req_w,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_ack,
  output logic        resp_err,
  output logic [31:0] resp_rdata
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic        resp_err_q, resp_err_d;
  logic        rd_zero_q, rd_zero_d;
  logic [1:0]  rd_lane_q, rd_lane_d;
  logic [1:0]  rd_size_q, rd_size_d;
  logic [31:0] mem_rdata_q;
  logic [31:0] mem [DEPTH];

  logic          accept, enter_resp, in_err;
  logic          eff_err, eff_write;
  logic [31:0]   eff_addr, eff_wdata, eff_wlanes;
  logic [1:0]    eff_size;
  logic [3:0]    eff_be;
  logic [AW-1:0] eff_idx;

  always_comb begin
    in_err = (req_r & req_w)
           | (req_size == 2'b11)
           | ((req_size == 2'b01) & req_addr[0])
           | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
           | ({1'b0, req_addr} < {1'b0, BASE_ADDR})
           | ({1'b0, req_addr} >= WIN_END);
  end

  assign accept     = (state_q == S_IDLE) & (req_r | req_w);
  assign enter_resp = (accept & (WAIT_STATES == 0)) | ((state_q == S_WAIT) & (cnt_q == 4'd1));

  // With zero wait states RESP is entered on the accept edge, so the live inputs are used.
  assign eff_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign eff_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign eff_size  = (state_q == S_IDLE) ? req_size  : size_q;
  assign eff_write = (state_q == S_IDLE) ? req_w     : write_q;
  assign eff_err   = (state_q == S_IDLE) ? in_err    : err_q;
  assign eff_idx   = AW'((eff_addr - BASE_ADDR) >> 2);

  always_comb begin
    eff_be     = 4'b1111;
    eff_wlanes = eff_wdata;
    case (eff_size)
      2'b00: begin
        eff_be     = 4'b0001 << eff_addr[1:0];
        eff_wlanes = {4{eff_wdata[7:0]}};
      end
      2'b01: begin
        eff_be     = eff_addr[1] ? 4'b1100 : 4'b0011;
        eff_wlanes = {2{eff_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // A reset on the edge that would enter RESP must not commit the pending write.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && !eff_err) begin
      if (eff_write) begin
        for (int i = 0; i < 4; i++) begin
          if (eff_be[i]) mem[eff_idx][8*i +: 8] <= eff_wlanes[8*i +: 8];
        end
      end else begin
        mem_rdata_q <= mem[eff_idx];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    write_d    = write_q;
    err_d      = err_q;
    resp_err_d = resp_err_q;
    rd_zero_d  = rd_zero_q;
    rd_lane_d  = rd_lane_q;
    rd_size_d  = rd_size_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          write_d = req_w;
          err_d   = in_err;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        state_d    = S_IDLE;
        resp_err_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      resp_err_d = eff_err;
      if (eff_err) begin
        rd_zero_d = 1'b1;
      end else if (!eff_write) begin
        rd_zero_d = 1'b0;
        rd_lane_d = eff_addr[1:0];
        rd_size_d = eff_size;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      resp_err_q <= 1'b0;
      rd_zero_q  <= 1'b1;
      rd_lane_q  <= '0;
      rd_size_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      write_q    <= write_d;
      err_q      <= err_d;
      resp_err_q <= resp_err_d;
      rd_zero_q  <= rd_zero_d;
      rd_lane_q  <= rd_lane_d;
      rd_size_q  <= rd_size_d;
    end
  end

  // Lane selection happens after the registered RAM read; the raw word stays in mem_rdata_q.
  always_comb begin
    case (rd_size_q)
      2'b00:   resp_rdata = {24'b0, mem_rdata_q[8*rd_lane_q +: 8]};
      2'b01:   resp_rdata = {16'b0, (rd_lane_q[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0])};
      default: resp_rdata = mem_rdata_q;
    endcase
    if (rd_zero_q) resp_rdata = '0;
  end

  assign busy     = (state_q != S_IDLE);
  assign resp_ack = (state_q == S_RESP);
  assign resp_err = resp_err_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: one instance with one wait state, one with none; expected
// responses are queued when a request is driven and compared when the ack arrives.
module tb_data_bus_responder;
  localparam logic [31:0] BASE  = 32'h2000_0100;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        r1, w1, r0, w0;
  logic [1:0]  sz1, sz0;
  logic [31:0] a1, wd1, a0, wd0;
  logic        busy1, ack1, err1, busy0, ack0, err0;
  logic [31:0] rd1, rd0;

  typedef struct { logic err; logic [31:0] rdata; int lat; } exp_t;
  typedef struct packed {
    logic r; logic w; logic [1:0] sz; logic [31:0] addr; logic [31:0] wd;
    logic eerr; logic [31:0] erd;
  } txn_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_bus_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .req_r(r1), .req_w(w1), .req_size(sz1), .req_addr(a1),
    .req_wdata(wd1), .busy(busy1), .resp_ack(ack1), .resp_err(err1), .resp_rdata(rd1)
  );

  data_bus_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(0)) dut_nw (
    .clk(clk), .rst(rst), .req_r(r0), .req_w(w0), .req_size(sz0), .req_addr(a0),
    .req_wdata(wd0), .busy(busy0), .resp_ack(ack0), .resp_err(err0), .resp_rdata(rd0)
  );

  // Drives one request once the target is idle, waits (bounded) for ack and returns what it saw.
  task automatic issue(input bit z, input logic r, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, output int lat,
                       output logic err, output logic [31:0] rd, output bit busy_ok);
    int n;
    busy_ok = 1'b1;
    lat = -1;
    err = 1'b0;
    rd = '0;
    n = 0;
    @(negedge clk);
    while ((z ? busy0 : busy1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (z) begin r0 = r; w0 = w; sz0 = sz; a0 = a; wd0 = wd; end
    else   begin r1 = r; w1 = w; sz1 = sz; a1 = a; wd1 = wd; end
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!(z ? busy0 : busy1)) busy_ok = 1'b0;
    end while (!(z ? ack0 : ack1) && n < 30);
    if (z ? ack0 : ack1) begin
      lat = n;
      err = z ? err0 : err1;
      rd  = z ? rd0 : rd1;
    end
    if (z) begin r0 = 1'b0; w0 = 1'b0; end
    else   begin r1 = 1'b0; w1 = 1'b0; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks += 8;
    if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy1); end
    if (ack1 !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", ack1); end
    if (err1 !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err1); end
    if (rd1 !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", rd1); end
    if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy_nw got=%b want=0", busy0); end
    if (ack0 !== 1'b0) begin failures++; $display("FAIL reset_ack_nw got=%b want=0", ack0); end
    if (err0 !== 1'b0) begin failures++; $display("FAIL reset_err_nw got=%b want=0", err0); end
    if (rd0 !== 32'h0) begin failures++; $display("FAIL reset_rdata_nw got=%h want=0", rd0); end
    $display("test_reset done");
  endtask

  task automatic test_word_rw();
    txn_t tbl [2] = '{
      '{1'b0, 1'b1, 2'b10, BASE + 32'd8, 32'hDEADBEEF, 1'b0, 32'h0},
      '{1'b1, 1'b0, 2'b10, BASE + 32'd8, 32'h0,        1'b0, 32'hDEADBEEF}
    };
    int lat; logic err; logic [31:0] rd; bit bok; exp_t e;
    foreach (tbl[i]) begin
      sb.push_back('{tbl[i].eerr, tbl[i].erd, 2});
      issue(1'b0, tbl[i].r, tbl[i].w, tbl[i].sz, tbl[i].addr, tbl[i].wd, lat, err, rd, bok);
      e = sb.pop_front();
      checks += 4;
      if (lat !== e.lat) begin failures++; $display("FAIL word_rw[%0d] latency got=%0d want=%0d", i, lat, e.lat); end
      if (err !== e.err) begin failures++; $display("FAIL word_rw[%0d] err got=%b want=%b", i, err, e.err); end
      if (rd !== e.rdata) begin failures++; $display("FAIL word_rw[%0d] rdata got=%h want=%h", i, rd, e.rdata); end
      if (!bok) begin failures++; $display("FAIL word_rw[%0d] busy got=0 want=1", i); end
      $display("word_rw[%0d] addr=%h lat=%0d err=%b rdata=%h", i, tbl[i].addr, lat, err, rd);
    end
  endtask

  task automatic test_lanes();
    txn_t tbl [3] = '{
      '{1'b0, 1'b1, 2'b00, BASE + 32'd9,  32'hFFFF_FF5A, 1'b0, 32'hDEADBEEF},
      '{1'b1, 1'b0, 2'b01, BASE + 32'd8,  32'h0,         1'b0, 32'h0000_5AEF},
      '{1'b1, 1'b0, 2'b00, BASE + 32'd11, 32'h0,         1'b0, 32'h0000_00DE}
    };
    int lat; logic err; logic [31:0] rd; bit bok; exp_t e;
    foreach (tbl[i]) begin
      sb.push_back('{tbl[i].eerr, tbl[i].erd, 2});
      issue(1'b0, tbl[i].r, tbl[i].w, tbl[i].sz, tbl[i].addr, tbl[i].wd, lat, err, rd, bok);
      e = sb.pop_front();
      checks += 3;
      if (lat !== e.lat) begin failures++; $display("FAIL lanes[%0d] latency got=%0d want=%0d", i, lat, e.lat); end
      if (err !== e.err) begin failures++; $display("FAIL lanes[%0d] err got=%b want=%b", i, err, e.err); end
      if (rd !== e.rdata) begin failures++; $display("FAIL lanes[%0d] rdata got=%h want=%h", i, rd, e.rdata); end
      $display("lanes[%0d] addr=%h size=%0d err=%b rdata=%h", i, tbl[i].addr, tbl[i].sz, err, rd);
    end
  endtask

  task automatic test_errors();
    txn_t tbl [9] = '{
      '{1'b0, 1'b1, 2'b10, BASE + 32'(4*(DEPTH-1)), 32'hA5A5_0001, 1'b0, 32'h0000_00DE},
      '{1'b1, 1'b0, 2'b10, BASE + 32'(4*(DEPTH-1)), 32'h0,         1'b0, 32'hA5A5_0001},
      '{1'b1, 1'b0, 2'b01, BASE + 32'd3,            32'h0,         1'b1, 32'h0},
      '{1'b1, 1'b0, 2'b10, BASE + 32'd6,            32'h0,         1'b1, 32'h0},
      '{1'b1, 1'b0, 2'b11, BASE + 32'd8,            32'h0,         1'b1, 32'h0},
      '{1'b1, 1'b0, 2'b10, BASE + 32'(4*DEPTH),     32'h0,         1'b1, 32'h0},
      '{1'b1, 1'b1, 2'b10, BASE + 32'd8,            32'h1111_1111, 1'b1, 32'h0},
      '{1'b0, 1'b1, 2'b10, BASE - 32'd4,            32'h2222_2222, 1'b1, 32'h0},
      '{1'b1, 1'b0, 2'b10, BASE + 32'd8,            32'h0,         1'b0, 32'hDEAD5AEF}
    };
    int lat; logic err; logic [31:0] rd; bit bok; exp_t e;
    foreach (tbl[i]) begin
      sb.push_back('{tbl[i].eerr, tbl[i].erd, 2});
      issue(1'b0, tbl[i].r, tbl[i].w, tbl[i].sz, tbl[i].addr, tbl[i].wd, lat, err, rd, bok);
      e = sb.pop_front();
      checks += 3;
      if (lat !== e.lat) begin failures++; $display("FAIL errors[%0d] latency got=%0d want=%0d", i, lat, e.lat); end
      if (err !== e.err) begin failures++; $display("FAIL errors[%0d] err got=%b want=%b", i, err, e.err); end
      if (rd !== e.rdata) begin failures++; $display("FAIL errors[%0d] rdata got=%h want=%h", i, rd, e.rdata); end
      $display("errors[%0d] addr=%h size=%0d r=%b w=%b err=%b rdata=%h", i, tbl[i].addr, tbl[i].sz,
               tbl[i].r, tbl[i].w, err, rd);
      if (e.err) begin
        @(posedge clk);
        #1;
        checks += 2;
        if (err1 !== 1'b0) begin failures++; $display("FAIL errors[%0d] err_clear got=%b want=0", i, err1); end
        if (rd1 !== 32'h0) begin failures++; $display("FAIL errors[%0d] rdata_hold got=%h want=0", i, rd1); end
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic err; logic [31:0] rd; bit bok; exp_t e; int pulses; int n;
    sb.push_back('{1'b0, 32'hDEAD5AEF, 2});
    issue(1'b0, 1'b0, 1'b1, 2'b10, BASE + 32'd4, 32'hCAFEF00D, lat, err, rd, bok);
    e = sb.pop_front();
    checks += 2;
    if (lat !== e.lat) begin failures++; $display("FAIL abort_prewrite latency got=%0d want=%0d", lat, e.lat); end
    if (rd !== e.rdata) begin failures++; $display("FAIL abort_prewrite rdata got=%h want=%h", rd, e.rdata); end
    n = 0;
    @(negedge clk);
    while (busy1 && n < 20) begin @(negedge clk); n++; end
    w1 = 1'b1; sz1 = 2'b10; a1 = BASE + 32'd4; wd1 = 32'h12345678;
    pulses = 0;
    @(posedge clk);
    #1;
    checks++;
    if (busy1 !== 1'b1) begin failures++; $display("FAIL abort_in_wait busy got=%b want=1", busy1); end
    if (ack1) pulses++;
    @(negedge clk);
    rst = 1'b1;
    w1 = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (ack1) pulses++; end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (ack1) pulses++; end
    checks += 2;
    if (pulses !== 0) begin failures++; $display("FAIL abort_ack pulses got=%0d want=0", pulses); end
    if (busy1 !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy1); end
    sb.push_back('{1'b0, 32'hCAFEF00D, 2});
    issue(1'b0, 1'b1, 1'b0, 2'b10, BASE + 32'd4, 32'h0, lat, err, rd, bok);
    e = sb.pop_front();
    checks += 3;
    if (lat !== e.lat) begin failures++; $display("FAIL abort_read latency got=%0d want=%0d", lat, e.lat); end
    if (err !== e.err) begin failures++; $display("FAIL abort_read err got=%b want=%b", err, e.err); end
    if (rd !== e.rdata) begin failures++; $display("FAIL abort_read rdata got=%h want=%h", rd, e.rdata); end
    $display("reset_abort pulses=%0d readback=%h", pulses, rd);
  endtask

  task automatic test_back_to_back();
    int lat; logic err; logic [31:0] rd; bit bok; exp_t e; logic want;
    sb.push_back('{1'b0, 32'h0, 1});
    issue(1'b1, 1'b0, 1'b1, 2'b10, BASE + 32'd8, 32'h0BADF00D, lat, err, rd, bok);
    e = sb.pop_front();
    checks += 2;
    if (lat !== e.lat) begin failures++; $display("FAIL b2b_write latency got=%0d want=%0d", lat, e.lat); end
    if (err !== e.err) begin failures++; $display("FAIL b2b_write err got=%b want=%b", err, e.err); end
    @(negedge clk);
    @(negedge clk);
    r0 = 1'b1; sz0 = 2'b10; a0 = BASE + 32'd8;
    for (int i = 0; i < 4; i++) sb.push_back('{1'b0, 32'h0BADF00D, 1});
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      want = ((i % 2) == 0);
      checks += 2;
      if (ack0 !== want) begin failures++; $display("FAIL b2b[%0d] ack got=%b want=%b", i, ack0, want); end
      if (busy0 !== want) begin failures++; $display("FAIL b2b[%0d] busy got=%b want=%b", i, busy0, want); end
      if (ack0 && sb.size() > 0) begin
        e = sb.pop_front();
        checks += 2;
        if (err0 !== e.err) begin failures++; $display("FAIL b2b[%0d] err got=%b want=%b", i, err0, e.err); end
        if (rd0 !== e.rdata) begin failures++; $display("FAIL b2b[%0d] rdata got=%h want=%h", i, rd0, e.rdata); end
      end
      $display("b2b[%0d] ack=%b busy=%b rdata=%h", i, ack0, busy0, rd0);
    end
    r0 = 1'b0;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL b2b_drain pending got=%0d want=0", sb.size()); end
    sb.delete();
  endtask

  initial begin
    rst = 1'b1;
    r1 = 1'b0; w1 = 1'b0; sz1 = 2'b00; a1 = '0; wd1 = '0;
    r0 = 1'b0; w0 = 1'b0; sz0 = 2'b00; a0 = '0; wd0 = '0;
    test_reset();
    test_word_rw();
    test_lanes();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
